// File: rtl/imem_bridge.sv
// Instruction fetch bridge: one 64-bit doubleword fetch in flight, forwarded im_* -> bm_*; optional line buffer via IMEM_LINE_BUF_EN.
// Latency: miss = 3 cycles accept-to-response with a zero-wait bus; buffer hit = 1 cycle.
// Backpressure: im_req_ready low while a fetch is in flight; bm_req held until bm_req_ready; im_resp has no backpressure.
module imem_bridge #(
    parameter int          ADDR_WIDTH = 64,
    parameter logic [63:0] FAULT_DATA = 64'h00000013_00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           im_req_addr,
    input  logic                  im_req_valid,
    output logic                  im_req_ready,
    output logic [63:0]           im_resp_rdata,
    output logic                  im_resp_valid,
    input  logic                  buf_inv,
    output logic [ADDR_WIDTH-1:0] bm_req_addr,
    output logic                  bm_req_valid,
    input  logic                  bm_req_ready,
    input  logic [63:0]           bm_resp_rdata,
    input  logic                  bm_resp_valid,
    input  logic                  bm_resp_err
);

`ifdef IMEM_LINE_BUF_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_HIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_bm_req_vld;
    logic [ADDR_WIDTH-1:0] r_bm_req_addr;
    logic [63:0]           r_resp_rdata;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_hit;
    logic [63:0]           w_hit_dat;
    logic                  w_unused;

`ifdef IMEM_LINE_BUF_EN
    logic        r_buf_vld;
    logic [60:0] r_buf_tag;
    logic [63:0] r_buf_dat;
    logic [60:0] r_req_tag;

    // A same-cycle invalidate must not be bypassed by a hit on stale data.
    assign w_hit         = r_buf_vld && (r_buf_tag == im_req_addr[63:3]) && !buf_inv;
    assign w_hit_dat     = r_buf_dat;
    assign w_can_accept  = (r_state == S_IDLE) || (r_state == S_RESP) || (r_state == S_HIT);
    assign im_resp_valid = ((r_state == S_RESP) || (r_state == S_HIT)) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld <= 1'b0;
            r_req_tag <= '0;
        end else begin
            if (w_accept) begin
                r_req_tag <= im_req_addr[63:3];
            end
            if ((r_state == S_WAIT) && bm_resp_valid) begin
                r_buf_vld <= !bm_resp_err;
                if (!bm_resp_err) begin
                    r_buf_tag <= r_req_tag;
                    r_buf_dat <= bm_resp_rdata;
                end
            end
            if (buf_inv) begin
                r_buf_vld <= 1'b0;
            end
        end
    end
`else
    assign w_hit         = 1'b0;
    assign w_hit_dat     = '0;
    assign w_can_accept  = (r_state == S_IDLE) || (r_state == S_RESP);
    assign im_resp_valid = (r_state == S_RESP) && !rst;
`endif

    assign im_req_ready  = w_can_accept && !rst;
    assign w_accept      = im_req_valid && im_req_ready;
    assign im_resp_rdata = r_resp_rdata;
    assign bm_req_valid  = r_bm_req_vld;
    assign bm_req_addr   = r_bm_req_addr;
    assign w_unused      = ^{im_req_addr, buf_inv};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (bm_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bm_resp_valid) begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = w_accept ? S_REQ : S_IDLE;
`ifdef IMEM_LINE_BUF_EN
                if (w_accept && w_hit) begin
                    w_state_nxt = S_HIT;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bm_req_vld  <= 1'b0;
            r_bm_req_addr <= '0;
            r_resp_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_REQ) && bm_req_ready) begin
                r_bm_req_vld <= 1'b0;
            end
            if ((r_state == S_WAIT) && bm_resp_valid) begin
                r_resp_rdata <= bm_resp_err ? FAULT_DATA : bm_resp_rdata;
            end
            if (w_accept && w_hit) begin
                r_resp_rdata <= w_hit_dat;
            end
            if (w_accept && !w_hit) begin
                r_bm_req_vld  <= 1'b1;
                r_bm_req_addr <= {im_req_addr[ADDR_WIDTH-1:3], 3'b000};
            end
        end
    end

endmodule
